// File: rtl/spi_reg_config.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_reg_config : SPI-slave (mode 0) write decoder owning the five PWM control
// registers. Optional macro SPI_READBACK_EN enables register readback on cipo.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_reg_config #(
  parameter int NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] ACTIVE    = 1'b1;
  localparam logic [4:0] CNT_FULL  = 5'd16;
  localparam logic [4:0] CNT_SAT   = 5'd17;
  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

  logic [2:0]  sclk_s;
  logic [2:0]  ncs_s;
  logic [1:0]  copi_s;
  logic [0:0]  state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic [1:0]  settle;
  logic        armed;
  logic [7:0]  regs [5];

  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, commit;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign ncs_fall  = ~ncs_s[1] & ncs_s[2];
  assign ncs_rise  = ncs_s[1] & ~ncs_s[2];

  assign commit = (state == ACTIVE) && ncs_rise && (bit_cnt == CNT_FULL) &&
                  shift_reg[15] && (shift_reg[14:8] < NUM_REGS_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= 3'b000;
      ncs_s  <= 3'b111;
      copi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      ncs_s  <= {ncs_s[1:0], ncs};
      copi_s <= {copi_s[0], copi};
    end
  end

  // The ncs chain resets high, so a pin held low through reset would look like a
  // falling edge. Only arm frame start once the chain has flushed and seen ncs high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle[1] && ncs_s[1]) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (ncs_fall && armed) begin
            state     <= ACTIVE;
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
          end
        end
        ACTIVE: begin
          if (ncs_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s[1]};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= commit;
      for (int i = 0; i < 5; i++) begin
        if (commit && (shift_reg[14:8] == 7'(i))) regs[i] <= shift_reg[7:0];
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

`ifdef SPI_READBACK_EN
  logic [7:0] out_sr;

  // After 8 bits the shifter holds {R/W, address}; a read of a valid address
  // loads the register so its MSB is on cipo before the 9th sclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr <= 8'h00;
    end else if (state != ACTIVE || ncs_s[1]) begin
      out_sr <= 8'h00;
    end else if (sclk_fall) begin
      if (bit_cnt == 5'd8 && !shift_reg[7] && (shift_reg[6:0] < NUM_REGS_A))
        out_sr <= regs[shift_reg[2:0]];
      else
        out_sr <= {out_sr[6:0], 1'b0};
    end
  end

  assign cipo = out_sr[7];
`else
  assign cipo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/spi_reg_config.md
# spi_reg_config

SPI-slave configuration controller that owns the five 8-bit control registers feeding the PWM peripheral: output enables, PWM enables and duty cycle. It synchronises the external SPI pins into the system clock domain and decodes 16-bit write frames. It commits a register only when a frame is complete and valid, so the PWM datapath never sees a partial update. It sits between the top-level `ui_in` pins and the `pwm_peripheral` instance.

## Interface
Parameters:
- `NUM_REGS`, 5: number of implemented registers; addresses `0..NUM_REGS-1`, all others ignored.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`; mode 0 (CPOL=0, CPHA=0).
- `ncs` in 1: SPI chip select, active low, asynchronous.
- `copi` in 1: SPI data in, asynchronous.
- `cipo` out 1: SPI data out; readback only (see Configuration).
- `en_reg_out_7_0` out 8: address 0x00.
- `en_reg_out_15_8` out 8: address 0x01.
- `en_reg_pwm_7_0` out 8: address 0x02.
- `en_reg_pwm_15_8` out 8: address 0x03.
- `pwm_duty_cycle` out 8: address 0x04.
- `cfg_update` out 1: one-`clk` pulse on every committed register write.

## Operation
- **Synchronisers:** `sclk`, `ncs` and `copi` each pass through a 2-FF synchroniser, followed by a third FF for edge detection.
  - Reset values: `ncs` chain 1; `sclk` and `copi` chains 0.
- **Frame format:** 16 bits, MSB first, sampled on synchronised `sclk` rising edges while `ncs` is low.
  - Bit 15: R/W (1 = write).
  - Bits 14:8: address.
  - Bits 7:0: data.
- **FSM states:**
  - IDLE → ACTIVE on `ncs` falling edge: clear bit counter and shift register.
  - ACTIVE: shift `copi` in on each `sclk` rise; the 5-bit bit counter saturates at 17.
  - ACTIVE → IDLE on `ncs` rising edge: evaluate the frame.
- **Commit rule:** a register is written only if all of the following hold; otherwise nothing changes and `cfg_update` stays 0.
  - Bit count is exactly 16.
  - Bit 15 is 1.
  - Address is less than `NUM_REGS`.
- **Short or long frames:** fewer than 16 or more than 16 bits → frame discarded.
- **Reset release with `ncs` low:** the FSM stays in IDLE; that frame is ignored, and the next `ncs` falling edge starts a new frame.
- **Reset mid-frame:** registers return to 0x00 and the partial frame is lost.
- **Reset values:** all five registers 0x00; `cfg_update` 0; `cipo` 0.
- **`sclk` edges while `ncs` is high:** ignored.

## Timing
- **Host pin constraints:**
  - `sclk` high and low phases: ≥ 4 `clk` periods each.
  - `ncs` fall to first `sclk` rise: ≥ 4 `clk` periods.
  - Last `sclk` fall to `ncs` rise: ≥ 4 `clk` periods.
  - `ncs` high between frames: ≥ 4 `clk` periods.
- **Sampling:** `copi` is sampled from the synchroniser output on the same `clk` edge that detects the `sclk` rise. Host must hold `copi` stable ≥ 3 `clk` periods around the `sclk` rise.
- **Commit latency:** register output and `cfg_update` both change on the 3rd `clk` rising edge after `ncs` goes high, assuming setup is met at the first edge. `cfg_update` is high for exactly that one cycle.
- **Register outputs:** driven directly from flops, no combinational path from pins. Registers hold their value between commits.

## Configuration
- **Macro:** `SPI_READBACK_EN`.
- **Defined:** a frame with bit 15 = 0 and a valid address is a read.
  - On the 8th synchronised `sclk` falling edge, an 8-bit output shift register loads the addressed register and drives its MSB on `cipo`.
  - It shifts on each following `sclk` fall.
  - `cipo` updates ≤ 3 `clk` after the `sclk` fall and is stable by the next rise, given the 4-period low phase.
  - `cipo` is 0 while `ncs` is high, during the address phase, for invalid addresses and for writes.
  - Reads never modify registers or pulse `cfg_update`.
- **Undefined:** `cipo` is tied to 0. Read frames are discarded like any other invalid frame.

## Test plan
- **Reset:** assert `rst_n`=0 mid-operation → all five registers 0x00, `cipo`=0, `cfg_update`=0, asynchronously.
- **Valid write:** frame 0x8455 (write, addr 0x04, data 0x55), `sclk` = `clk`/10 → `pwm_duty_cycle`=0x55 and one-cycle `cfg_update` on the 3rd `clk` edge after `ncs` rises; other registers unchanged.
- **Full map:** write 0x01, 0x02, 0x04, 0x08, 0xF0 to addresses 0x00–0x04 → each output holds its value; none is disturbed by the others.
- **Rejected frames:** each of the following → no register change, no `cfg_update`.
  - 15-bit frame 0x80FF.
  - 17-bit frame.
  - Write to addr 0x05.
  - Frame 0x00AA (bit 15 = 0).
- **Reset release with `ncs` low:** release `rst_n` while `ncs` is low, clock 16 bits of 0x8177, raise `ncs` → ignored. Next full 0x8177 frame → `en_reg_out_15_8`=0x77.
- **Readback (`SPI_READBACK_EN` only):** after writing 0xA5 to 0x02, read frame 0x02xx → `cipo` sampled on rises 9–16 returns 1,0,1,0,0,1,0,1.
